lbist_ora: RTL and testbench
============================

LBIST_ORA -- requirements
Module: lbist_ora

Interface
REQ-001 Parameter WIDTH, default 239: number of CUT primary outputs compacted.
REQ-002 Parameter TAP_MASK, default WIDTH'(1)<<36: MISR feedback taps for x^239+x^36+1. Bit i set means sig[WIDTH-1] is XORed into stage i; bit 0 is ignored.
REQ-003 Parameter SEED, default 0: MISR value loaded on start.
REQ-004 Parameter SKIP_CYCLES, default 2: valid cycles discarded while the CUT pipeline fills; 0 is legal.
REQ-005 Parameter N_PATTERNS, default 1024: valid cycles compacted; must be >= 1.
REQ-006 Parameter GOLDEN, default 0: expected final signature.
REQ-007 clk  input  1  single clock, rising edge.
REQ-008 rst_n  input  1  asynchronous, active-low reset.
REQ-009 start  input  1  single-cycle request to begin a session.
REQ-010 pos_valid  input  1  pos carries a valid CUT response this cycle.
REQ-011 pos  input  WIDTH  CUT primary outputs.
REQ-012 busy  output  1  high in SKIP, COMPACT and COMPARE.
REQ-013 test_over  output  1  high in DONE.
REQ-014 go_nogo  output  1  1 = signature matched GOLDEN; valid only while test_over=1.
REQ-015 signature  output  WIDTH  current MISR contents.

Function
REQ-016 The FSM SHALL have states IDLE, SKIP, COMPACT, COMPARE and DONE.
REQ-017 IDLE/DONE with start=1: load signature=SEED, clear skip and pattern counters, clear test_over and go_nogo; go to SKIP, or to COMPACT if SKIP_CYCLES=0.
REQ-018 start SHALL be ignored in SKIP, COMPACT and COMPARE.
REQ-019 SKIP: each cycle with pos_valid=1 increments the skip counter; pos is not compacted; after the SKIP_CYCLES-th valid cycle, go to COMPACT.
REQ-020 COMPACT: each cycle with pos_valid=1 updates the MISR:
- next[0] = sig[W-1]^pos[0]
- next[i] = sig[i-1]^pos[i]^(TAP_MASK[i]&sig[W-1]) for i >= 1
REQ-021 COMPACT: on the N_PATTERNS-th valid cycle, perform the MISR update and go to COMPARE.
REQ-022 pos_valid=0 SHALL freeze the MISR, both counters and the state, except for transitions out of IDLE/DONE and COMPARE.
REQ-023 COMPARE, one cycle: go_nogo <= (signature==GOLDEN); test_over <= 1; go to DONE.
REQ-024 DONE: hold signature, go_nogo and test_over until the next start or reset.
REQ-025 Latency: test_over rises exactly 1 cycle after the clock edge that performed the final MISR update.
REQ-026 Counter widths SHALL be $clog2(max+1), so no counter wraps before its terminal count.
REQ-027 Arithmetic is GF(2): XOR only, no carries, signature width exactly WIDTH.

Reset
REQ-028 rst_n=0 SHALL immediately force state=IDLE, signature=0, counters=0, busy=0, test_over=0 and go_nogo=0.
REQ-029 Reset asserted mid-session SHALL abort the session; no result is reported; a new start is required after rst_n=1.

Verification
REQ-030 Bench parameters WIDTH=4, TAP_MASK=4'b0010, SEED=0, SKIP_CYCLES=0, N_PATTERNS=2, pos_valid=1:
- pos=0001, then pos=0001 -> signature 0001 then 0011.
- GOLDEN=4'b0011 -> test_over=1 and go_nogo=1 on the cycle after the second update.
REQ-031 Same sequence with GOLDEN=4'b0000 -> go_nogo=0, test_over=1.
REQ-032 SKIP_CYCLES=2, pos=1111 on the first 2 valid cycles, then the REQ-030 stimulus -> identical signature 0011 (skipped data not compacted).
REQ-033 pos_valid=0 for 5 cycles inside COMPACT -> signature and counters unchanged; final signature and test_over timing shifted by exactly 5 cycles.
REQ-034 start pulsed in COMPACT -> ignored (result identical to REQ-030); start in DONE -> test_over/go_nogo clear next cycle, signature=SEED.
REQ-035 rst_n pulsed low mid-COMPACT -> all outputs 0 asynchronously, state IDLE; no test_over until a fresh start completes.

Source files
------------

// File: rtl/lbist_ora.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | lbist_ora : LBIST output response analyser (MISR compactor + golden check) |
// | Rev 1.0                                                                    |
// +----------------------------------------------------------------------------+
module lbist_ora #(
  parameter int               WIDTH       = 239,
  parameter logic [WIDTH-1:0] TAP_MASK    = WIDTH'(1) << 36,
  parameter logic [WIDTH-1:0] SEED        = '0,
  parameter int               SKIP_CYCLES = 2,
  parameter int               N_PATTERNS  = 1024,
  parameter logic [WIDTH-1:0] GOLDEN      = '0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             pos_valid,
  input  logic [WIDTH-1:0] pos,
  output logic             busy,
  output logic             test_over,
  output logic             go_nogo,
  output logic [WIDTH-1:0] signature
);

  // A zero-length skip counter is illegal, so keep at least one bit.
  localparam int SKIP_CW = (SKIP_CYCLES > 0) ? $clog2(SKIP_CYCLES + 1) : 1;
  localparam int PAT_CW  = $clog2(N_PATTERNS + 1);

  localparam logic [SKIP_CW-1:0] SKIP_LAST = SKIP_CW'((SKIP_CYCLES > 0) ? SKIP_CYCLES - 1 : 0);
  localparam logic [PAT_CW-1:0]  PAT_LAST  = PAT_CW'(N_PATTERNS - 1);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_SKIP    = 3'd1,
    ST_COMPACT = 3'd2,
    ST_COMPARE = 3'd3,
    ST_DONE    = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [WIDTH-1:0]   sig_q, sig_d;
  logic [SKIP_CW-1:0] skip_cnt_q, skip_cnt_d;
  logic [PAT_CW-1:0]  pat_cnt_q, pat_cnt_d;
  logic               test_over_q, test_over_d;
  logic               go_nogo_q, go_nogo_d;
  logic [WIDTH-1:0]   misr_next;

  // Galois-style MISR: the MSB feeds back into stage 0 and every tapped stage.
  always_comb begin
    misr_next    = '0;
    misr_next[0] = sig_q[WIDTH-1] ^ pos[0];
    for (int i = 1; i < WIDTH; i++) begin
      misr_next[i] = sig_q[i-1] ^ pos[i] ^ (TAP_MASK[i] & sig_q[WIDTH-1]);
    end
  end

  always_comb begin
    state_d     = state_q;
    sig_d       = sig_q;
    skip_cnt_d  = skip_cnt_q;
    pat_cnt_d   = pat_cnt_q;
    test_over_d = test_over_q;
    go_nogo_d   = go_nogo_q;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        if (start) begin
          sig_d       = SEED;
          skip_cnt_d  = '0;
          pat_cnt_d   = '0;
          test_over_d = 1'b0;
          go_nogo_d   = 1'b0;
          state_d     = (SKIP_CYCLES == 0) ? ST_COMPACT : ST_SKIP;
        end
      end
      ST_SKIP: begin
        if (pos_valid) begin
          skip_cnt_d = skip_cnt_q + SKIP_CW'(1);
          if (skip_cnt_q == SKIP_LAST) begin
            state_d = ST_COMPACT;
          end
        end
      end
      ST_COMPACT: begin
        if (pos_valid) begin
          sig_d     = misr_next;
          pat_cnt_d = pat_cnt_q + PAT_CW'(1);
          if (pat_cnt_q == PAT_LAST) begin
            state_d = ST_COMPARE;
          end
        end
      end
      ST_COMPARE: begin
        go_nogo_d   = (sig_q == GOLDEN);
        test_over_d = 1'b1;
        state_d     = ST_DONE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      sig_q       <= '0;
      skip_cnt_q  <= '0;
      pat_cnt_q   <= '0;
      test_over_q <= 1'b0;
      go_nogo_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      sig_q       <= sig_d;
      skip_cnt_q  <= skip_cnt_d;
      pat_cnt_q   <= pat_cnt_d;
      test_over_q <= test_over_d;
      go_nogo_q   <= go_nogo_d;
    end
  end

  // busy decodes straight from state so reset clears it without a clock.
  assign busy      = (state_q == ST_SKIP) || (state_q == ST_COMPACT) || (state_q == ST_COMPARE);
  assign test_over = test_over_q;
  assign go_nogo   = go_nogo_q;
  assign signature = sig_q;

endmodule
`default_nettype wire

// File: tb/tb_lbist_ora.sv
`default_nettype none
// Directed bench for lbist_ora: four small instances share one clock/reset.
module tb_lbist_ora;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  int n_vec = 0;
  int n_err = 0;

  // Instances a/b: SKIP=0, N=2, GOLDEN 0011 / 0000, common stimulus.
  logic       ab_start = 1'b0, ab_valid = 1'b0;
  logic [3:0] ab_pos = 4'h0;
  logic       a_busy, a_over, a_go, b_busy, b_over, b_go;
  logic [3:0] a_sig, b_sig;
  // Instance c: SKIP=2, N=2, GOLDEN 0011.
  logic       c_start = 1'b0, c_valid = 1'b0;
  logic [3:0] c_pos = 4'h0;
  logic       c_busy, c_over, c_go;
  logic [3:0] c_sig;
  // Instance d: SKIP=0, N=6, GOLDEN 1001.
  logic       d_start = 1'b0, d_valid = 1'b0;
  logic [3:0] d_pos = 4'h0;
  logic       d_busy, d_over, d_go;
  logic [3:0] d_sig;

  lbist_ora #(.WIDTH(4), .TAP_MASK(4'b0010), .SEED(4'b0000), .SKIP_CYCLES(0),
              .N_PATTERNS(2), .GOLDEN(4'b0011)) dut_a (
    .clk(clk), .rst_n(rst_n), .start(ab_start), .pos_valid(ab_valid), .pos(ab_pos),
    .busy(a_busy), .test_over(a_over), .go_nogo(a_go), .signature(a_sig));

  lbist_ora #(.WIDTH(4), .TAP_MASK(4'b0010), .SEED(4'b0000), .SKIP_CYCLES(0),
              .N_PATTERNS(2), .GOLDEN(4'b0000)) dut_b (
    .clk(clk), .rst_n(rst_n), .start(ab_start), .pos_valid(ab_valid), .pos(ab_pos),
    .busy(b_busy), .test_over(b_over), .go_nogo(b_go), .signature(b_sig));

  lbist_ora #(.WIDTH(4), .TAP_MASK(4'b0010), .SEED(4'b0000), .SKIP_CYCLES(2),
              .N_PATTERNS(2), .GOLDEN(4'b0011)) dut_c (
    .clk(clk), .rst_n(rst_n), .start(c_start), .pos_valid(c_valid), .pos(c_pos),
    .busy(c_busy), .test_over(c_over), .go_nogo(c_go), .signature(c_sig));

  lbist_ora #(.WIDTH(4), .TAP_MASK(4'b0010), .SEED(4'b0000), .SKIP_CYCLES(0),
              .N_PATTERNS(6), .GOLDEN(4'b1001)) dut_d (
    .clk(clk), .rst_n(rst_n), .start(d_start), .pos_valid(d_valid), .pos(d_pos),
    .busy(d_busy), .test_over(d_over), .go_nogo(d_go), .signature(d_sig));

  // Status word layout: {busy, test_over, go_nogo, signature[3:0]}
  typedef struct {
    logic       st;
    logic       v;
    logic [3:0] pos;
    logic [6:0] exp;
  } vec_t;

  vec_t tbl[11];

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [6:0] act, input logic [6:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got {busy,over,go,sig}=%b expected %b", nm, act, exp);
    end
  endtask

  initial begin
    // Hand-computed MISR trace for taps x^4+x^1+1 (fb into stages 0 and 1).
    tbl[0]  = '{st: 1'b1, v: 1'b0, pos: 4'b0000, exp: 7'b100_0000};
    tbl[1]  = '{st: 1'b0, v: 1'b1, pos: 4'b1000, exp: 7'b100_1000};
    tbl[2]  = '{st: 1'b0, v: 1'b1, pos: 4'b0000, exp: 7'b100_0011};
    tbl[3]  = '{st: 1'b0, v: 1'b0, pos: 4'b1111, exp: 7'b100_0011};
    tbl[4]  = '{st: 1'b0, v: 1'b1, pos: 4'b0100, exp: 7'b100_0010};
    tbl[5]  = '{st: 1'b0, v: 1'b1, pos: 4'b1010, exp: 7'b100_1110};
    tbl[6]  = '{st: 1'b0, v: 1'b0, pos: 4'b0000, exp: 7'b100_1110};
    tbl[7]  = '{st: 1'b0, v: 1'b1, pos: 4'b0001, exp: 7'b100_1110};
    tbl[8]  = '{st: 1'b0, v: 1'b1, pos: 4'b0110, exp: 7'b100_1001};
    tbl[9]  = '{st: 1'b0, v: 1'b0, pos: 4'b0000, exp: 7'b011_1001};
    tbl[10] = '{st: 1'b1, v: 1'b0, pos: 4'b0000, exp: 7'b100_0000};

    // Reset state
    repeat (2) step();
    chk("reset_a", {a_busy, a_over, a_go, a_sig}, 7'b000_0000);
    chk("reset_d", {d_busy, d_over, d_go, d_sig}, 7'b000_0000);
    rst_n = 1'b1;
    step();

    // Basic session, matching and mismatching golden
    ab_start = 1'b1;
    step();
    ab_start = 1'b0;
    chk("ab_start", {a_busy, a_over, a_go, a_sig}, 7'b100_0000);
    ab_valid = 1'b1; ab_pos = 4'b0001;
    step();
    chk("ab_upd1", {a_busy, a_over, a_go, a_sig}, 7'b100_0001);
    step();
    chk("ab_upd2", {a_busy, a_over, a_go, a_sig}, 7'b100_0011);
    ab_valid = 1'b0;
    step();
    chk("a_done_pass", {a_busy, a_over, a_go, a_sig}, 7'b011_0011);
    chk("b_done_fail", {b_busy, b_over, b_go, b_sig}, 7'b010_0011);
    step();
    chk("a_done_hold", {a_busy, a_over, a_go, a_sig}, 7'b011_0011);

    // Restart from DONE, then a 5-cycle stall inside COMPACT
    ab_start = 1'b1;
    step();
    ab_start = 1'b0;
    chk("a_restart", {a_busy, a_over, a_go, a_sig}, 7'b100_0000);
    ab_valid = 1'b1;
    step();
    chk("a_stall_pre", {a_busy, a_over, a_go, a_sig}, 7'b100_0001);
    ab_valid = 1'b0; ab_pos = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("a_stall", {a_busy, a_over, a_go, a_sig}, 7'b100_0001);
    end
    ab_valid = 1'b1; ab_pos = 4'b0001;
    step();
    ab_valid = 1'b0;
    chk("a_stall_upd2", {a_busy, a_over, a_go, a_sig}, 7'b100_0011);
    step();
    chk("a_stall_done", {a_busy, a_over, a_go, a_sig}, 7'b011_0011);

    // start held high throughout COMPACT must be ignored
    ab_start = 1'b1;
    step();
    ab_valid = 1'b1;
    step();
    chk("a_start_ign1", {a_busy, a_over, a_go, a_sig}, 7'b100_0001);
    step();
    ab_start = 1'b0; ab_valid = 1'b0;
    chk("a_start_ign2", {a_busy, a_over, a_go, a_sig}, 7'b100_0011);
    step();
    chk("a_start_ign_done", {a_busy, a_over, a_go, a_sig}, 7'b011_0011);

    // Skipped responses must not reach the MISR; a gap must not advance SKIP
    c_start = 1'b1;
    step();
    c_start = 1'b0;
    chk("c_skip_entry", {c_busy, c_over, c_go, c_sig}, 7'b100_0000);
    c_valid = 1'b1; c_pos = 4'b1111;
    step();
    c_valid = 1'b0;
    step();
    c_valid = 1'b1;
    step();
    chk("c_skip_end", {c_busy, c_over, c_go, c_sig}, 7'b100_0000);
    c_pos = 4'b0001;
    step();
    chk("c_upd1", {c_busy, c_over, c_go, c_sig}, 7'b100_0001);
    step();
    c_valid = 1'b0;
    chk("c_upd2", {c_busy, c_over, c_go, c_sig}, 7'b100_0011);
    step();
    chk("c_done", {c_busy, c_over, c_go, c_sig}, 7'b011_0011);

    // Table-driven longer session with stalls and feedback activity
    for (int k = 0; k < 11; k++) begin
      d_start = tbl[k].st;
      d_valid = tbl[k].v;
      d_pos   = tbl[k].pos;
      step();
      chk($sformatf("d_vec%0d", k), {d_busy, d_over, d_go, d_sig}, tbl[k].exp);
    end
    d_start = 1'b0; d_valid = 1'b0;

    // Asynchronous reset mid-COMPACT aborts the session
    ab_start = 1'b1;
    step();
    ab_start = 1'b0; ab_valid = 1'b1; ab_pos = 4'b0001;
    step();
    chk("a_pre_rst", {a_busy, a_over, a_go, a_sig}, 7'b100_0001);
    #2 rst_n = 1'b0;
    #1;
    chk("a_async_rst", {a_busy, a_over, a_go, a_sig}, 7'b000_0000);
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("a_post_rst_idle", {a_busy, a_over, a_go, a_sig}, 7'b000_0000);
    end
    ab_start = 1'b1;
    step();
    ab_start = 1'b0;
    step();
    step();
    ab_valid = 1'b0;
    chk("a_fresh_upd2", {a_busy, a_over, a_go, a_sig}, 7'b100_0011);
    step();
    chk("a_fresh_done", {a_busy, a_over, a_go, a_sig}, 7'b011_0011);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
